// File: rtl/ara_pe_req_broadcaster.sv
// Request buffer between the vector sequencer and the processing elements.
// Each head request is broadcast to its target PEs and retired once all of them accepted it.
package ara_pe_req_pkg;
    localparam int unsigned NrVInsn     = 4;
    localparam int unsigned OffsetLoad  = 0;
    localparam int unsigned OffsetStore = 1;
    localparam int unsigned OffsetSlide = 2;
    localparam int unsigned OffsetMask  = 3;

    typedef struct packed {
        logic [3:0]         id;
        logic [7:0]         op;
        logic [NrVInsn-1:0] vinsn_running;
        logic [NrVInsn-1:0] hazard_vs1;
        logic [NrVInsn-1:0] hazard_vs2;
        logic [NrVInsn-1:0] hazard_vd;
        logic [NrVInsn-1:0] hazard_vm;
    } pe_req_t;
endpackage

module ara_pe_req_broadcaster
    import ara_pe_req_pkg::*;
#(
    parameter int unsigned NrLanes = 1,
    parameter int unsigned Depth   = 2,
    localparam int unsigned NrPEs  = NrLanes + 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  pe_req_t            pe_req_i,
    input  logic [NrPEs-1:0]   pe_req_target_i,
    input  logic               pe_req_valid_i,
    output logic               pe_req_ready_o,
    input  logic [NrVInsn-1:0] vinsn_done_i,
    output pe_req_t            pe_req_o,
    output logic [NrPEs-1:0]   pe_req_valid_o,
    input  logic [NrPEs-1:0]   pe_req_ready_i,
    output logic               idle_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        pe_req_t          req;
        logic [NrPEs-1:0] target;
    } entry_t;

    function automatic pe_req_t clear_hazards(pe_req_t r, logic [NrVInsn-1:0] done);
        pe_req_t c;
        c               = r;
        c.vinsn_running = r.vinsn_running & ~done;
        c.hazard_vs1    = r.hazard_vs1 & ~done;
        c.hazard_vs2    = r.hazard_vs2 & ~done;
        c.hazard_vd     = r.hazard_vd & ~done;
        c.hazard_vm     = r.hazard_vm & ~done;
        return c;
    endfunction

    function automatic logic [PtrW-1:0] ptr_next(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    entry_t           mem [Depth];
    logic [PtrW-1:0]  rptr, wptr;
    logic [CntW-1:0]  count;
    logic [NrPEs-1:0] acked;
    logic [NrPEs-1:0] handshake;
    logic             not_empty, push, pop;

    assign not_empty      = (count != '0);
    assign idle_o         = !not_empty;
    assign pe_req_ready_o = (count != CntW'(Depth));
    assign pe_req_o       = not_empty ? mem[rptr].req : '0;
    assign pe_req_valid_o = not_empty ? (mem[rptr].target & ~acked) : '0;
    assign handshake      = pe_req_valid_o & pe_req_ready_i;
    // An empty target mask retires immediately since nothing is left to accept it.
    assign pop            = not_empty && ((mem[rptr].target & ~(acked | handshake)) == '0);
    assign push           = pe_req_valid_i && pe_req_ready_o;

    for (genvar i = 0; i < Depth; i++) begin : g_entry
        entry_t q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q <= '0;
            end else if (push && (wptr == PtrW'(i))) begin
                q.req    <= clear_hazards(pe_req_i, vinsn_done_i);
                q.target <= pe_req_target_i;
            end else begin
                q.req <= clear_hazards(q.req, vinsn_done_i);
            end
        end
        assign mem[i] = q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            acked <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (pop) begin
                rptr  <= ptr_next(rptr);
                acked <= '0;
            end else begin
                acked <= acked | handshake;
            end
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_ara_pe_req_broadcaster.sv
// Directed and random stimulus against a queue-based reference of the broadcaster.
module tb_ara_pe_req_broadcaster;
   import ara_pe_req_pkg::*;

   localparam int unsigned NL  = 2;
   localparam int unsigned D   = 2;
   localparam int unsigned NPE = NL + 4;

   logic               clk = 1'b0;
   logic               rst_n;
   pe_req_t            req_in;
   logic [NPE-1:0]     tgt_in;
   logic               vld_in;
   logic               rdy_out;
   logic [NrVInsn-1:0] done_in;
   pe_req_t            req_out;
   logic [NPE-1:0]     vld_out;
   logic [NPE-1:0]     rdy_in;
   logic               idle;

   int checks = 0;
   int errors = 0;

   pe_req_t        mq[$];
   logic [NPE-1:0] tq[$];
   logic [NPE-1:0] acked_m;

   always #5 clk = ~clk;

   ara_pe_req_broadcaster #(.NrLanes(NL), .Depth(D)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .pe_req_i       (req_in),
      .pe_req_target_i(tgt_in),
      .pe_req_valid_i (vld_in),
      .pe_req_ready_o (rdy_out),
      .vinsn_done_i   (done_in),
      .pe_req_o       (req_out),
      .pe_req_valid_o (vld_out),
      .pe_req_ready_i (rdy_in),
      .idle_o         (idle)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pe_req_t clr(pe_req_t r, logic [NrVInsn-1:0] d);
      pe_req_t c = r;
      c.vinsn_running &= ~d;
      c.hazard_vs1    &= ~d;
      c.hazard_vs2    &= ~d;
      c.hazard_vd     &= ~d;
      c.hazard_vm     &= ~d;
      return c;
   endfunction

   function automatic pe_req_t mk(int id, logic [3:0] hvs1, logic [3:0] run);
      pe_req_t r = '0;
      r.id            = 4'(id);
      r.op            = 8'(8'hA0 + id);
      r.hazard_vs1    = hvs1;
      r.vinsn_running = run;
      r.hazard_vd     = run;
      return r;
   endfunction

   // Compare outputs against the reference, then advance both across one edge.
   task automatic step();
      pe_req_t        er;
      logic [NPE-1:0] ev, hs;
      logic           ps, pp;
      #1;
      er = (mq.size() > 0) ? mq[0] : '0;
      ev = (mq.size() > 0) ? (tq[0] & ~acked_m) : '0;
      chk("valid_o", 64'(vld_out), 64'(ev));
      chk("req_o", 64'(req_out), 64'(er));
      chk("ready_o", 64'(rdy_out), 64'(mq.size() != D));
      chk("idle_o", 64'(idle), 64'(mq.size() == 0));
      hs = ev & rdy_in;
      pp = (mq.size() > 0) && ((tq[0] & ~(acked_m | hs)) == '0);
      ps = vld_in && (mq.size() != D);
      @(posedge clk);
      #1;
      foreach (mq[i]) mq[i] = clr(mq[i], done_in);
      if (pp) begin
         void'(mq.pop_front());
         void'(tq.pop_front());
         acked_m = '0;
      end else begin
         acked_m |= hs;
      end
      if (ps) begin
         mq.push_back(clr(req_in, done_in));
         tq.push_back(tgt_in);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      req_in  = '0;
      tgt_in  = '0;
      vld_in  = 1'b0;
      done_in = '0;
      rdy_in  = '0;
      acked_m = '0;
      #1;
      chk("rst_ready", 64'(rdy_out), 64'(1'b1));
      chk("rst_valid", 64'(vld_out), 64'(6'b0));
      chk("rst_req", 64'(req_out), 64'(0));
      chk("rst_idle", 64'(idle), 64'(1'b1));
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      req_in = mk(3, 4'h0, 4'h0); tgt_in = 6'b000011; rdy_in = '1; vld_in = 1'b1;
      step();
      vld_in = 1'b0;
      #1 chk("bc_lanes_valid", 64'(vld_out), 64'(6'b000011));
      step();
      #1 chk("bc_idle_t2", 64'(idle), 64'(1'b1));
      step();

      req_in = mk(5, 4'h0, 4'h0); tgt_in = 6'b000101; rdy_in = 6'b111011; vld_in = 1'b1;
      step();
      vld_in = 1'b0;
      step();
      #1 chk("stall_load_only", 64'(vld_out), 64'(6'b000100));
      repeat (3) step();
      chk("stall_req_stable", 64'(req_out.id), 64'(4'd5));
      rdy_in = '1;
      step();
      step();

      rdy_in = '0; tgt_in = '1;
      for (int i = 0; i < 3; i++) begin
         req_in = mk(8 + i, 4'h0, 4'h0); vld_in = 1'b1;
         step();
      end
      vld_in = 1'b0;
      chk("full_ready_low", 64'(rdy_out), 64'(1'b0));
      rdy_in = '1;
      repeat (4) step();

      rdy_in = '0; tgt_in = 6'b000001;
      req_in = mk(1, 4'b0110, 4'h0); vld_in = 1'b1;
      step();
      req_in = mk(2, 4'b0000, 4'b1111); done_in = 4'b0010;
      step();
      vld_in = 1'b0; done_in = '0;
      #1 chk("hazard_vs1_cleared", 64'(req_out.hazard_vs1), 64'(4'b0100));
      rdy_in = '1;
      repeat (3) step();

      rdy_in = '0; tgt_in = '0; req_in = mk(6, 4'h0, 4'h0); vld_in = 1'b1;
      step();
      vld_in = 1'b0;
      #1 chk("tgt0_no_valid", 64'(vld_out), 64'(6'b0));
      step();
      #1 chk("tgt0_idle", 64'(idle), 64'(1'b1));

      tgt_in = '1;
      req_in = mk(10, 4'h0, 4'h0); vld_in = 1'b1; step();
      req_in = mk(11, 4'h0, 4'h0); step();
      vld_in = 1'b0; rdy_in = 6'b000001;
      step();
      rdy_in = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(rdy_out), 64'(1'b1));
      chk("arst_valid", 64'(vld_out), 64'(6'b0));
      chk("arst_req", 64'(req_out), 64'(0));
      chk("arst_idle", 64'(idle), 64'(1'b1));
      mq.delete(); tq.delete(); acked_m = '0;
      #2 rst_n = 1'b1;
      req_in = mk(12, 4'h0, 4'h0); tgt_in = 6'b000010; vld_in = 1'b1;
      step();
      vld_in = 1'b0;
      #1 chk("post_rst_head", 64'(req_out.id), 64'(4'd12));
      rdy_in = '1;
      step();
      step();

      for (int n = 0; n < 300; n++) begin
         vld_in  = 1'($urandom);
         req_in  = pe_req_t'($urandom);
         tgt_in  = NPE'($urandom);
         rdy_in  = NPE'($urandom);
         done_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
         step();
      end
      vld_in = 1'b0; rdy_in = '1; done_in = '0;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
